// File: rtl/ysyx_24110006_pkg.sv
// Shared types and constants for the load/store unit.
package ysyx_24110006_pkg;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_REQ  = 2'd1,
        LSU_WAIT = 2'd2,
        LSU_DONE = 2'd3
    } lsu_state_e;

    localparam logic [2:0] RT_LB  = 3'b000;
    localparam logic [2:0] RT_LH  = 3'b001;
    localparam logic [2:0] RT_LW  = 3'b010;
    localparam logic [2:0] RT_LBU = 3'b100;
    localparam logic [2:0] RT_LHU = 3'b101;

    localparam logic [3:0] MCAUSE_LD_MISALIGN = 4'd4;
    localparam logic [3:0] MCAUSE_LD_FAULT    = 4'd5;
    localparam logic [3:0] MCAUSE_ST_MISALIGN = 4'd6;
    localparam logic [3:0] MCAUSE_ST_FAULT    = 4'd7;

    localparam logic [3:0] WMASK_H = 4'b0011;
    localparam logic [3:0] WMASK_W = 4'b1111;

    // Stores size by their byte mask, loads by the low bits of funct3.
    function automatic logic is_misaligned(input logic       is_store,
                                           input logic [3:0] wmask,
                                           input logic [2:0] read_t,
                                           input logic [1:0] addr_lo);
        logic half;
        logic word;
        half = is_store ? (wmask == WMASK_H) : (read_t[1:0] == 2'b01);
        word = is_store ? (wmask == WMASK_W) : (read_t[1:0] == 2'b10);
        return (half && addr_lo[0]) || (word && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/ysyx_24110006_lsu_if.sv
// Data bus between the LSU (master) and memory (slave); names follow the LSU's view.
interface ysyx_24110006_lsu_if #(
    parameter int XLEN = 32
);
    logic              o_req;
    logic              o_we;
    logic [XLEN-1:0]   o_addr;
    logic [XLEN-1:0]   o_wdata;
    logic [XLEN/8-1:0] o_wstrb;
    logic              i_gnt;
    logic              i_rvalid;
    logic [XLEN-1:0]   i_rdata;
    logic              i_err;

    modport master (
        output o_req, o_we, o_addr, o_wdata, o_wstrb,
        input  i_gnt, i_rvalid, i_rdata, i_err
    );

    modport slave (
        input  o_req, o_we, o_addr, o_wdata, o_wstrb,
        output i_gnt, i_rvalid, i_rdata, i_err
    );
endinterface

// File: rtl/ysyx_24110006_lsu_align.sv
// Byte-lane steering: store data/strobe shift toward the lane, load extract and extension.
module ysyx_24110006_lsu_align
    import ysyx_24110006_pkg::*;
(
    input  logic [1:0]  st_off_i,
    input  logic [3:0]  wmask_i,
    input  logic [31:0] wdata_i,
    output logic [3:0]  wstrb_o,
    output logic [31:0] wdata_o,
    input  logic [1:0]  ld_off_i,
    input  logic [2:0]  read_t_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] ldata_o
);
    logic [31:0] shifted;

    always_comb begin
        wstrb_o = wmask_i << st_off_i;
        wdata_o = wdata_i << {st_off_i, 3'b000};
        shifted = rdata_i >> {ld_off_i, 3'b000};
        case (read_t_i)
            RT_LB:   ldata_o = {{24{shifted[7]}}, shifted[7:0]};
            RT_LH:   ldata_o = {{16{shifted[15]}}, shifted[15:0]};
            RT_LBU:  ldata_o = {24'd0, shifted[7:0]};
            RT_LHU:  ldata_o = {16'd0, shifted[15:0]};
            default: ldata_o = shifted;
        endcase
    end
endmodule

// File: rtl/ysyx_24110006_lsu.sv
// Load/store unit between execute and writeback; one outstanding bus transaction at a time.
//   state | meaning
//   IDLE  | accepting; non-memory and misaligned ops complete from here
//   REQ   | o_req held until the bus grants
//   WAIT  | granted, waiting for the response strobe
//   DONE  | response captured, o_valid up; back to IDLE next cycle
module ysyx_24110006_lsu
    import ysyx_24110006_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            i_clock,
    input  logic            i_reset,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [XLEN-1:0] i_result,
    input  logic            i_reg_wen,
    input  logic [4:0]      i_reg_rd,
    input  logic [XLEN-1:0] i_pc,
    input  logic            i_mem_ren,
    input  logic            i_mem_wen,
    input  logic [3:0]      i_mem_wmask,
    input  logic [2:0]      i_mem_read_t,
    input  logic [XLEN-1:0] i_mem_addr,
    input  logic [XLEN-1:0] i_mem_wdata,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [XLEN-1:0] o_result,
    output logic            o_reg_wen,
    output logic [4:0]      o_reg_rd,
    output logic [XLEN-1:0] o_pc,
    output logic            o_exception,
    output logic [3:0]      o_mcause,
    ysyx_24110006_lsu_if.master bus
);
    lsu_state_e      state_q;
    logic            valid_q;
    logic            req_q;
    logic            we_q;
    logic            exc_q;
    logic [3:0]      mcause_q;
    logic [3:0]      wstrb_q;

    logic [XLEN-1:0] result_q;
    logic            reg_wen_q;
    logic [4:0]      rd_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;
    logic [1:0]      off_q;
    logic [2:0]      read_t_q;

    logic            accept;
    logic            is_mem;
    logic            misalign;
    logic            rsp_take;
    logic [3:0]      st_wstrb;
    logic [31:0]     st_wdata;
    logic [31:0]     ld_data;

    assign o_ready  = (state_q == LSU_IDLE) && (!valid_q || i_ready);
    assign accept   = i_valid && o_ready;
    assign is_mem   = i_mem_ren || i_mem_wen;
    assign misalign = is_mem && is_misaligned(i_mem_wen, i_mem_wmask, i_mem_read_t, i_mem_addr[1:0]);
    // A response counts only while a request is outstanding; stray strobes are dropped.
    assign rsp_take = bus.i_rvalid &&
                      (((state_q == LSU_REQ) && bus.i_gnt) || (state_q == LSU_WAIT));

    ysyx_24110006_lsu_align u_align (
        .st_off_i (i_mem_addr[1:0]),
        .wmask_i  (i_mem_wmask),
        .wdata_i  (i_mem_wdata),
        .wstrb_o  (st_wstrb),
        .wdata_o  (st_wdata),
        .ld_off_i (off_q),
        .read_t_i (read_t_q),
        .rdata_i  (bus.i_rdata),
        .ldata_o  (ld_data)
    );

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q  <= LSU_IDLE;
            valid_q  <= 1'b0;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            exc_q    <= 1'b0;
            mcause_q <= 4'd0;
            wstrb_q  <= 4'd0;
        end else begin
            if (valid_q && i_ready) valid_q <= 1'b0;
            case (state_q)
                LSU_IDLE: begin
                    if (accept) begin
                        we_q     <= i_mem_wen;
                        wstrb_q  <= (i_mem_wen && !misalign) ? st_wstrb : 4'd0;
                        exc_q    <= misalign;
                        mcause_q <= !misalign ? 4'd0 :
                                    (i_mem_wen ? MCAUSE_ST_MISALIGN : MCAUSE_LD_MISALIGN);
                        if (is_mem && !misalign) begin
                            state_q <= LSU_REQ;
                            req_q   <= 1'b1;
                        end else begin
                            valid_q <= 1'b1;
                        end
                    end
                end
                LSU_REQ: begin
                    if (bus.i_gnt) begin
                        req_q   <= 1'b0;
                        state_q <= bus.i_rvalid ? LSU_DONE : LSU_WAIT;
                    end
                end
                LSU_WAIT: begin
                    if (bus.i_rvalid) state_q <= LSU_DONE;
                end
                LSU_DONE: state_q <= LSU_IDLE;
                default:  state_q <= LSU_IDLE;
            endcase
            if (rsp_take) begin
                valid_q <= 1'b1;
                if (bus.i_err) begin
                    exc_q    <= 1'b1;
                    mcause_q <= we_q ? MCAUSE_ST_FAULT : MCAUSE_LD_FAULT;
                end
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (accept) begin
            result_q  <= i_result;
            reg_wen_q <= i_reg_wen && !i_mem_wen && !misalign;
            rd_q      <= i_reg_rd;
            pc_q      <= i_pc;
            addr_q    <= {i_mem_addr[XLEN-1:2], 2'b00};
            wdata_q   <= st_wdata;
            off_q     <= i_mem_addr[1:0];
            read_t_q  <= i_mem_read_t;
        end else if (rsp_take) begin
            if (!we_q) result_q <= ld_data;
            if (bus.i_err) reg_wen_q <= 1'b0;
        end
    end

    assign o_valid      = valid_q;
    assign o_result     = result_q;
    assign o_reg_wen    = reg_wen_q;
    assign o_reg_rd     = rd_q;
    assign o_pc         = pc_q;
    assign o_exception  = exc_q;
    assign o_mcause     = mcause_q;

    assign bus.o_req    = req_q;
    assign bus.o_we     = we_q;
    assign bus.o_addr   = addr_q;
    assign bus.o_wdata  = wdata_q;
    assign bus.o_wstrb  = wstrb_q;
endmodule

// File: tb/tb_ysyx_24110006_lsu.sv
// Directed bench for the LSU with a transaction-level model and per-cycle compare.
module tb_ysyx_24110006_lsu;

    typedef struct {
        logic [31:0] result;
        logic        chk_res;
        logic        reg_wen;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic        exc;
        logic [3:0]  mcause;
        int          vcyc;
    } wb_t;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } bus_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_valid, o_ready, i_reg_wen, i_mem_ren, i_mem_wen;
    logic        o_valid, i_ready, o_reg_wen, o_exception;
    logic [31:0] i_result, i_pc, i_mem_addr, i_mem_wdata, o_result, o_pc;
    logic [4:0]  i_reg_rd, o_reg_rd;
    logic [3:0]  i_mem_wmask, o_mcause;
    logic [2:0]  i_mem_read_t;

    ysyx_24110006_lsu_if bus ();

    ysyx_24110006_lsu dut (
        .i_clock      (clk),
        .i_reset      (rst_n),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .i_result     (i_result),
        .i_reg_wen    (i_reg_wen),
        .i_reg_rd     (i_reg_rd),
        .i_pc         (i_pc),
        .i_mem_ren    (i_mem_ren),
        .i_mem_wen    (i_mem_wen),
        .i_mem_wmask  (i_mem_wmask),
        .i_mem_read_t (i_mem_read_t),
        .i_mem_addr   (i_mem_addr),
        .i_mem_wdata  (i_mem_wdata),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_result     (o_result),
        .o_reg_wen    (o_reg_wen),
        .o_reg_rd     (o_reg_rd),
        .o_pc         (o_pc),
        .o_exception  (o_exception),
        .o_mcause     (o_mcause),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;
    wb_t  exp_q[$];
    bus_t bexp_q[$];
    logic head_seen = 1'b0;
    int   req_cycles = 0;
    int   valid_cycles = 0;
    int   seq = 0;

    logic        bus_auto;
    int          gnt_dly, rsp_dly;
    logic [31:0] rsp_data;
    logic        rsp_err;

    logic [31:0] last_addr, last_wdata, last_result;
    logic [3:0]  last_wstrb, last_mcause;
    logic        last_we, last_exc, last_reg_wen;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // Per-cycle compare of bus request and writeback payload against the model queues.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.o_req) begin
                req_cycles++;
                if (bexp_q.size() == 0) begin
                    chk("unexpected_req", {31'd0, bus.o_req}, 32'd0);
                end else begin
                    chk("bus_addr", bus.o_addr, bexp_q[0].addr);
                    chk("bus_we", {31'd0, bus.o_we}, {31'd0, bexp_q[0].we});
                    chk("bus_wstrb", {28'd0, bus.o_wstrb}, {28'd0, bexp_q[0].wstrb});
                    if (bexp_q[0].we) chk("bus_wdata", bus.o_wdata, bexp_q[0].wdata);
                    if (bus.i_gnt) begin
                        last_addr  = bus.o_addr;
                        last_we    = bus.o_we;
                        last_wstrb = bus.o_wstrb;
                        last_wdata = bus.o_wdata;
                        void'(bexp_q.pop_front());
                    end
                end
            end
            if (o_valid) begin
                valid_cycles++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_valid", {31'd0, o_valid}, 32'd0);
                end else begin
                    if (!head_seen) begin
                        chk("latency", cyc, exp_q[0].vcyc);
                        head_seen = 1'b1;
                    end
                    if (exp_q[0].chk_res) chk("wb_result", o_result, exp_q[0].result);
                    chk("wb_reg_wen", {31'd0, o_reg_wen}, {31'd0, exp_q[0].reg_wen});
                    chk("wb_rd", {27'd0, o_reg_rd}, {27'd0, exp_q[0].rd});
                    chk("wb_pc", o_pc, exp_q[0].pc);
                    chk("wb_exception", {31'd0, o_exception}, {31'd0, exp_q[0].exc});
                    if (exp_q[0].exc) chk("wb_mcause", {28'd0, o_mcause}, {28'd0, exp_q[0].mcause});
                    if (i_ready) begin
                        last_result  = o_result;
                        last_exc     = o_exception;
                        last_mcause  = o_mcause;
                        last_reg_wen = o_reg_wen;
                        void'(exp_q.pop_front());
                        head_seen = 1'b0;
                    end
                end
            end
        end
    end

    // Memory responder: grant after gnt_dly cycles, respond rsp_dly cycles after grant.
    initial begin
        bus.i_gnt = 1'b0;
        bus.i_rvalid = 1'b0;
        bus.i_rdata = 32'd0;
        bus.i_err = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (bus_auto && bus.o_req) begin
                repeat (gnt_dly) begin @(posedge clk); #1; end
                bus.i_gnt = 1'b1;
                if (rsp_dly == 0) begin
                    bus.i_rvalid = 1'b1;
                    bus.i_rdata  = rsp_data;
                    bus.i_err    = rsp_err;
                end
                @(posedge clk); #1;
                bus.i_gnt = 1'b0;
                bus.i_rvalid = 1'b0;
                bus.i_err = 1'b0;
                if (rsp_dly > 0) begin
                    repeat (rsp_dly - 1) begin @(posedge clk); #1; end
                    bus.i_rvalid = 1'b1;
                    bus.i_rdata  = rsp_data;
                    bus.i_err    = rsp_err;
                    @(posedge clk); #1;
                    bus.i_rvalid = 1'b0;
                    bus.i_err = 1'b0;
                end
            end
        end
    end

    task automatic issue(input logic ren, input logic wen, input logic [3:0] wmask,
                         input logic [2:0] rt, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] res, input int g, input int r,
                         input logic [31:0] rdata, input logic err);
        wb_t w;
        bus_t b;
        int off, size, n;
        logic mem, mis;
        logic [31:0] lane, v;
        i_valid = 1'b1; i_result = res; i_reg_wen = 1'b1;
        i_reg_rd = 5'(seq); i_pc = 32'h8000_0000 + 32'(seq * 4);
        i_mem_ren = ren; i_mem_wen = wen; i_mem_wmask = wmask; i_mem_read_t = rt;
        i_mem_addr = addr; i_mem_wdata = wdata;
        n = 0;
        @(negedge clk);
        while (o_ready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        chk("accept", {31'd0, o_ready}, 32'd1);
        off  = int'(addr[1:0]);
        mem  = ren || wen;
        if (wen) size = (wmask == 4'b0001) ? 1 : (wmask == 4'b0011) ? 2 : 4;
        else     size = (rt[1:0] == 2'b00) ? 1 : (rt[1:0] == 2'b01) ? 2 : 4;
        mis = mem && ((off % size) != 0);
        w.rd = i_reg_rd; w.pc = i_pc; w.exc = 1'b0; w.mcause = 4'd0;
        w.reg_wen = 1'b1; w.result = res; w.chk_res = 1'b1;
        if (!mem) begin
            w.vcyc = cyc + 1;
        end else if (mis) begin
            w.vcyc = cyc + 1; w.exc = 1'b1; w.mcause = wen ? 4'd6 : 4'd4;
            w.reg_wen = 1'b0; w.chk_res = 1'b0;
        end else begin
            w.vcyc  = cyc + 2 + g + r;
            b.addr  = addr - 32'(off);
            b.we    = wen;
            b.wstrb = wen ? 4'(wmask << off) : 4'd0;
            b.wdata = wdata << (8 * off);
            bexp_q.push_back(b);
            lane = rdata >> (8 * off);
            case (rt)
                3'b000: begin v = lane & 32'hFF;   if (v >= 128)   v = v - 256;   end
                3'b001: begin v = lane & 32'hFFFF; if (v >= 32768) v = v - 65536; end
                3'b100: v = lane & 32'hFF;
                3'b101: v = lane & 32'hFFFF;
                default: v = lane;
            endcase
            w.result = v;
            if (err) begin
                w.exc = 1'b1; w.mcause = wen ? 4'd7 : 4'd5; w.reg_wen = 1'b0; w.chk_res = 1'b0;
            end else if (wen) begin
                w.reg_wen = 1'b0; w.chk_res = 1'b0;
            end
        end
        exp_q.push_back(w);
        gnt_dly = g; rsp_dly = r; rsp_data = rdata; rsp_err = err;
        seq++;
        @(posedge clk); #1;
        i_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin @(posedge clk); #1; n++; end
        chk(name, exp_q.size(), 32'd0);
    endtask

    task automatic alu(input logic [31:0] res);
        issue(1'b0, 1'b0, 4'd0, 3'd0, 32'd0, 32'd0, res, 0, 0, 32'd0, 1'b0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int r0, v0, n;

    initial begin
        rst_n = 1'b0; bus_auto = 1'b1; i_ready = 1'b1;
        i_valid = 1'b0; i_result = 0; i_reg_wen = 0; i_reg_rd = 0; i_pc = 0;
        i_mem_ren = 0; i_mem_wen = 0; i_mem_wmask = 0; i_mem_read_t = 0;
        i_mem_addr = 0; i_mem_wdata = 0;
        gnt_dly = 0; rsp_dly = 0; rsp_data = 0; rsp_err = 0;
        repeat (2) @(posedge clk); #1;
        chk("rst_valid", {31'd0, o_valid}, 32'd0);
        chk("rst_req", {31'd0, bus.o_req}, 32'd0);
        chk("rst_we", {31'd0, bus.o_we}, 32'd0);
        chk("rst_exc", {31'd0, o_exception}, 32'd0);
        chk("rst_wstrb", {28'd0, bus.o_wstrb}, 32'd0);
        chk("rst_mcause", {28'd0, o_mcause}, 32'd0);
        chk("rst_ready", {31'd0, o_ready}, 32'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        r0 = req_cycles;
        alu(32'h1234);
        drain("drain_alu");
        chk("alu_result", last_result, 32'h1234);
        chk("alu_no_req", req_cycles - r0, 32'd0);

        alu(32'h1111); alu(32'h2222); alu(32'h3333);
        drain("drain_b2b");
        chk("b2b_last", last_result, 32'h3333);

        issue(1'b1, 1'b0, 4'd0, 3'b000, 32'h8000_0003, 32'd0, 32'd0, 0, 1, 32'h80FF_0000, 1'b0);
        drain("drain_lb");
        chk("lb_addr", last_addr, 32'h8000_0000);
        chk("lb_result", last_result, 32'hFFFF_FF80);

        issue(1'b0, 1'b1, 4'b0011, 3'd0, 32'h8000_0002, 32'h0000_ABCD, 32'd0, 1, 0, 32'd0, 1'b0);
        drain("drain_sh");
        chk("sh_wstrb", {28'd0, last_wstrb}, 32'hC);
        chk("sh_wdata", last_wdata, 32'hABCD_0000);
        chk("sh_we", {31'd0, last_we}, 32'd1);
        chk("sh_reg_wen", {31'd0, last_reg_wen}, 32'd0);

        r0 = req_cycles;
        issue(1'b1, 1'b0, 4'd0, 3'b010, 32'h8000_0002, 32'd0, 32'd0, 0, 0, 32'd0, 1'b0);
        drain("drain_lw_mis");
        chk("lw_mis_exc", {31'd0, last_exc}, 32'd1);
        chk("lw_mis_mcause", {28'd0, last_mcause}, 32'd4);
        chk("lw_mis_no_req", req_cycles - r0, 32'd0);

        i_ready = 1'b0;
        issue(1'b1, 1'b0, 4'd0, 3'b101, 32'h8000_0006, 32'd0, 32'd0, 0, 0, 32'h8001_1234, 1'b0);
        n = 0;
        while (o_valid !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
        chk("hold_valid_rise", {31'd0, o_valid}, 32'd1);
        repeat (3) begin @(posedge clk); #1; end
        chk("hold_valid", {31'd0, o_valid}, 32'd1);
        chk("hold_result", o_result, 32'h0000_8001);
        i_ready = 1'b1;
        drain("drain_lhu");

        issue(1'b1, 1'b0, 4'd0, 3'b101, 32'h8000_0004, 32'd0, 32'd0, 0, 0, 32'h0, 1'b1);
        drain("drain_lhu_err");
        chk("lhu_err_mcause", {28'd0, last_mcause}, 32'd5);
        chk("lhu_err_reg_wen", {31'd0, last_reg_wen}, 32'd0);

        issue(1'b0, 1'b1, 4'b1111, 3'd0, 32'h8000_0001, 32'h1, 32'd0, 0, 0, 32'd0, 1'b0);
        drain("drain_sw_mis");
        chk("sw_mis_mcause", {28'd0, last_mcause}, 32'd6);

        issue(1'b0, 1'b1, 4'b0001, 3'd0, 32'h8000_0001, 32'h0000_005A, 32'd0, 2, 1, 32'd0, 1'b0);
        drain("drain_sb");
        chk("sb_wstrb", {28'd0, last_wstrb}, 32'h2);
        chk("sb_wdata", last_wdata, 32'h0000_5A00);

        issue(1'b0, 1'b1, 4'b1111, 3'd0, 32'h8000_0008, 32'hCAFE_F00D, 32'd0, 2, 2, 32'd0, 1'b1);
        drain("drain_sw_err");
        chk("sw_err_mcause", {28'd0, last_mcause}, 32'd7);

        issue(1'b1, 1'b0, 4'd0, 3'b001, 32'h8000_0002, 32'd0, 32'd0, 1, 1, 32'h8765_4321, 1'b0);
        issue(1'b1, 1'b0, 4'd0, 3'b100, 32'h8000_0001, 32'd0, 32'd0, 0, 2, 32'h0000_F100, 1'b0);
        issue(1'b1, 1'b0, 4'd0, 3'b010, 32'h8000_0004, 32'd0, 32'd0, 3, 0, 32'hDEAD_BEEF, 1'b0);
        drain("drain_loads");
        chk("lw_result", last_result, 32'hDEAD_BEEF);
        alu(32'h0000_0077);
        drain("drain_alu2");

        // Reset while waiting for a response; a late response must be ignored.
        bus_auto = 1'b0;
        issue(1'b1, 1'b0, 4'd0, 3'b010, 32'h8000_0010, 32'd0, 32'd0, 0, 0, 32'd0, 1'b0);
        bus.i_gnt = 1'b1;
        @(posedge clk); #1;
        bus.i_gnt = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_wait_req", {31'd0, bus.o_req}, 32'd0);
        chk("rst_wait_valid", {31'd0, o_valid}, 32'd0);
        exp_q.delete();
        bexp_q.delete();
        head_seen = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        v0 = valid_cycles;
        bus.i_rvalid = 1'b1;
        bus.i_rdata = 32'h1234_5678;
        @(posedge clk); #1;
        bus.i_rvalid = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        chk("late_rvalid_no_valid", valid_cycles - v0, 32'd0);
        chk("post_rst_ready", {31'd0, o_ready}, 32'd1);
        bus_auto = 1'b1;
        alu(32'h0000_0099);
        drain("drain_after_rst");
        chk("after_rst_result", last_result, 32'h99);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ysyx_24110006_lsu.md
YSYX_24110006_LSU -- requirements
Module: ysyx_24110006_lsu

Interface
REQ-001 Parameter: XLEN, 32, data and address width; only 32 is supported.
REQ-002 i_clock  in  1  sole clock; all state updates on its rising edge.
REQ-003 i_reset  in  1  asynchronous, active-low reset (asserted when 0).
REQ-004 i_valid  in  1  upstream (execute stage) instruction valid.
REQ-005 o_ready  out  1  LSU can accept; transfer occurs when i_valid && o_ready.
REQ-006 i_result  in  32  ALU result, passed through for non-load instructions.
REQ-007 i_reg_wen, i_reg_rd  in  1, 5  writeback enable and destination register.
REQ-008 i_pc  in  32  instruction PC.
REQ-009 i_mem_ren, i_mem_wen  in  1, 1  load and store request; never both set.
REQ-010 i_mem_wmask, i_mem_read_t  in  4, 3  store byte mask (0001/0011/1111) and load funct3.
REQ-011 i_mem_addr, i_mem_wdata  in  32, 32  effective address and unshifted store data.
REQ-012 o_valid  out  1  result valid to writeback stage.
REQ-013 i_ready  in  1  writeback stage accepts; transfer when o_valid && i_ready.
REQ-014 o_result, o_reg_wen, o_reg_rd, o_pc  out  32, 1, 5, 32  writeback payload.
REQ-015 o_exception, o_mcause  out  1, 4  trap flag and cause.
REQ-016 o_req, o_we  out  1, 1  bus request and write-enable.
REQ-017 o_addr, o_wdata, o_wstrb  out  32, 32, 4  word-aligned address, lane-shifted data, byte strobes.
REQ-018 i_gnt  in  1  bus accepted the request this cycle.
REQ-019 i_rvalid, i_rdata, i_err  in  1, 32, 1  response strobe, read word, error flag for that response.

Function
REQ-020 States: IDLE, REQ, WAIT, DONE.
REQ-021 o_ready = (state==IDLE) && (!o_valid || i_ready).
REQ-022 On accept, every input payload field is latched into internal registers.
REQ-023 On a non-memory accept, the LSU stays in IDLE, sets o_valid on the next cycle, and drives o_result = latched i_result.
REQ-024 On a memory accept with aligned address, the LSU enters REQ; o_req=1 from the next cycle until i_gnt.
REQ-025 Alignment: byte always aligned; half requires addr[0]==0; word requires addr[1:0]==0.
REQ-026 A misaligned access issues no bus request and produces o_valid next cycle with o_exception=1, o_mcause=4 (load) or 6 (store), o_reg_wen=0.
REQ-027 In REQ: o_addr = {addr[31:2],2'b00}; o_we = store; o_wstrb = wmask << addr[1:0]; o_wdata = wdata << (8*addr[1:0]); o_wstrb=0 for loads.
REQ-028 REQ->WAIT on i_gnt without i_rvalid; REQ->DONE on i_gnt && i_rvalid in the same cycle.
REQ-029 WAIT->DONE on i_rvalid; i_rvalid outside REQ/WAIT is ignored.
REQ-030 Load data: rdata >> (8*addr[1:0]); read_t 000 sign-extend byte, 001 sign-extend half, 010 word, 100 zero-extend byte, 101 zero-extend half.
REQ-031 The response is captured on i_rvalid; a store's o_result is don't-care and o_reg_wen=0 for stores.
REQ-032 i_err with i_rvalid sets o_exception=1, o_mcause=5 (load) or 7 (store), and o_reg_wen=0.
REQ-033 DONE asserts o_valid and returns to IDLE on the following cycle.
REQ-034 While o_valid && !i_ready, all o_* writeback outputs hold stable.
REQ-035 o_valid clears on i_ready unless a new non-memory accept occurs in the same cycle (back-to-back, 1 instruction per cycle).
REQ-036 Latency: non-memory 1 cycle; memory = 1 + cycles to i_gnt + cycles to i_rvalid + 1.

Reset
REQ-037 When i_reset==0: state=IDLE; o_valid, o_req, o_we, o_exception = 0; o_wstrb=0; o_mcause=0.
REQ-038 Reset mid-transaction abandons it without a retry; the bus is reset on the same signal.
REQ-039 Payload data registers have no reset.

Structure
REQ-040 Package ysyx_24110006_pkg holds the LSU state enum, read_t codes, and mcause constants 4, 5, 6, 7.
REQ-041 Sub-module ysyx_24110006_lsu_align (combinational) performs store lane shifting and load extract/extension.

Verification
REQ-042 ALU op, result 0x1234, i_ready=1 -> o_valid next cycle with o_result=0x1234, o_req never asserted.
REQ-043 lb addr 0x80000003, rdata 0x80FF_0000, gnt and rvalid one cycle apart -> o_req addr 0x80000000, o_result 0xFFFFFF80.
REQ-044 sh addr 0x80000002, wdata 0xABCD -> o_wstrb 1100, o_wdata 0xABCD0000, o_we=1, o_reg_wen=0.
REQ-045 lw addr 0x80000002 -> no o_req; o_exception=1, o_mcause=4.
REQ-046 lhu with i_gnt and i_rvalid same cycle, i_ready=0 for 3 cycles -> o_valid and o_result hold; i_err=1 case -> o_mcause=5.
REQ-047 Reset asserted while in WAIT -> o_req=0 and o_valid=0 immediately; a late i_rvalid produces no o_valid.
